// File: rtl/comparator_arbiter.sv
// comparator_arbiter: round-robin sharing of one external combinational
// magnitude comparator among NUM_REQ requesters, with a single backpressured
// response channel that returns the one-hot result tagged with the requester ID.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | comparator held in reset; arbitrate and accept one request
//   COMPARE | comparator out of reset for one cycle; capture its result
//   RESPOND | result presented on resp_*; wait for resp_ready
module comparator_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int IDW     = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [IDW-1:0]           resp_id,
  output logic                     resp_greater,
  output logic                     resp_equal,
  output logic                     resp_lesser,
  output logic                     resp_error,
  output logic [WIDTH-1:0]         cmp_a,
  output logic [WIDTH-1:0]         cmp_b,
  output logic                     cmp_reset,
  input  logic                     cmp_greater,
  input  logic                     cmp_equal,
  input  logic                     cmp_lesser,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] cur_id;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] scan_idx;
  logic           grant_found;
  logic           cmp_onehot;

  // Round-robin search: first valid requester after last_grant, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = IDW'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx;
      end
    end
  end

  assign cmp_onehot = ( cmp_greater && !cmp_equal && !cmp_lesser) ||
                      (!cmp_greater &&  cmp_equal && !cmp_lesser) ||
                      (!cmp_greater && !cmp_equal &&  cmp_lesser);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs. req_ready is gated by reset_n so a
  // held request is never acknowledged while reset is asserted.
  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    cmp_reset  = 1'b1;
    resp_valid = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (grant_found) begin
          req_ready[grant_id] = reset_n;
          state_nxt           = COMPARE;
        end
      end
      COMPARE: begin
        cmp_reset = 1'b0;
        state_nxt = RESPOND;
      end
      RESPOND: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand latch, result capture and fairness pointer. The pointer moves
  // only when a response completes, so an aborted transaction never
  // consumes its requester's turn.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmp_a        <= '0;
      cmp_b        <= '0;
      cur_id       <= '0;
      last_grant   <= IDW'(NUM_REQ - 1);
      resp_id      <= '0;
      resp_greater <= 1'b0;
      resp_equal   <= 1'b0;
      resp_lesser  <= 1'b0;
      resp_error   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            cmp_a  <= req_a[grant_id*WIDTH +: WIDTH];
            cmp_b  <= req_b[grant_id*WIDTH +: WIDTH];
            cur_id <= grant_id;
          end
        end
        COMPARE: begin
          resp_greater <= cmp_greater;
          resp_equal   <= cmp_equal;
          resp_lesser  <= cmp_lesser;
          resp_error   <= !cmp_onehot;
          resp_id      <= cur_id;
        end
        RESPOND: begin
          if (resp_ready) begin
            last_grant <= cur_id;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_arbiter.sv
// Self-checking bench for comparator_arbiter: a transaction-level reference
// model (pending requests, rotating priority pointer, in-flight age) plus a
// behavioural comparator whose result can be forced to an illegal pattern.
module tb_comparator_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;
  localparam int IDW     = 2;

  logic                     clk;
  logic                     reset_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [IDW-1:0]           resp_id;
  logic                     resp_greater;
  logic                     resp_equal;
  logic                     resp_lesser;
  logic                     resp_error;
  logic [WIDTH-1:0]         cmp_a;
  logic [WIDTH-1:0]         cmp_b;
  logic                     cmp_reset;
  logic                     cmp_greater;
  logic                     cmp_equal;
  logic                     cmp_lesser;
  logic                     busy;

  comparator_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_greater(resp_greater), .resp_equal(resp_equal),
    .resp_lesser(resp_lesser), .resp_error(resp_error),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_reset(cmp_reset),
    .cmp_greater(cmp_greater), .cmp_equal(cmp_equal), .cmp_lesser(cmp_lesser),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural comparator; force_err makes it report greater and equal together.
  logic force_err;
  always_comb begin
    cmp_greater = 1'b0;
    cmp_equal   = 1'b0;
    cmp_lesser  = 1'b0;
    if (!cmp_reset) begin
      cmp_greater = force_err | (cmp_a > cmp_b);
      cmp_equal   = force_err | (cmp_a == cmp_b);
      cmp_lesser  = !force_err & (cmp_a < cmp_b);
    end
  end

  int errors = 0;
  int checks = 0;

  // Requester-side stimulus state.
  logic [NUM_REQ-1:0] pend_v;
  logic [WIDTH-1:0]   pend_a [NUM_REQ];
  logic [WIDTH-1:0]   pend_b [NUM_REQ];
  logic               rr;

  // Reference model state.
  int   ptr;
  bit   inflight;
  int   age;
  int   cur_id;
  int   cur_a;
  int   cur_b;
  bit   cur_err;
  int   cyc;
  int   resp_ids[$];
  int   resp_cycs[$];
  int   acc_ids[$];
  int   acc_cycs[$];
  logic obs_gt, obs_eq, obs_lt, obs_err;

  typedef struct {
    int         id;
    logic [3:0] a;
    logic [3:0] b;
    bit         gt;
    bit         eq;
    bit         lt;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle, entered and left at a falling edge: drive, check against
  // the model, then advance the model across the rising edge.
  task automatic cycle();
    logic [NUM_REQ-1:0] exp_rdy;
    int  w;
    bit  exp_rv;
    req_valid  = pend_v;
    resp_ready = rr;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = pend_a[i];
      req_b[i*WIDTH +: WIDTH] = pend_b[i];
    end
    #1;
    exp_rdy = '0;
    w = -1;
    if (!inflight) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int i;
        i = (ptr + k) % NUM_REQ;
        if (w < 0 && pend_v[i]) w = i;
      end
    end
    if (w >= 0) exp_rdy[w] = 1'b1;
    exp_rv = inflight && (age >= 1);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(inflight));
    chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
    chk("cmp_reset", 32'(cmp_reset), 32'(!(inflight && age == 0)));
    if (inflight && age == 0) begin
      chk("cmp_a", 32'(cmp_a), 32'(cur_a));
      chk("cmp_b", 32'(cmp_b), 32'(cur_b));
    end
    if (exp_rv) begin
      chk("resp_id", 32'(resp_id), 32'(cur_id));
      chk("resp_greater", 32'(resp_greater), 32'(cur_err | (cur_a > cur_b)));
      chk("resp_equal", 32'(resp_equal), 32'(cur_err | (cur_a == cur_b)));
      chk("resp_lesser", 32'(resp_lesser), 32'(!cur_err & (cur_a < cur_b)));
      chk("resp_error", 32'(resp_error), 32'(cur_err));
      if (rr) begin
        obs_gt  = resp_greater;
        obs_eq  = resp_equal;
        obs_lt  = resp_lesser;
        obs_err = resp_error;
        resp_ids.push_back(int'(resp_id));
        resp_cycs.push_back(cyc);
      end
    end
    @(posedge clk);
    if (w >= 0) begin
      inflight = 1'b1;
      age      = 0;
      cur_id   = w;
      cur_a    = int'(pend_a[w]);
      cur_b    = int'(pend_b[w]);
      cur_err  = force_err;
      pend_v[w] = 1'b0;
      acc_ids.push_back(w);
      acc_cycs.push_back(cyc);
    end else if (exp_rv && rr) begin
      inflight = 1'b0;
      ptr      = cur_id;
    end else if (inflight) begin
      age++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until(input int maxc);
    int n;
    n = 0;
    while ((inflight || pend_v != '0) && n < maxc) begin
      cycle();
      n++;
    end
    checks++;
    if (inflight || pend_v != '0) begin
      errors++;
      $display("FAIL drain_timeout: got busy after %0d cycles, expected idle", maxc);
    end
  endtask

  task automatic model_reset();
    inflight = 1'b0;
    age      = 0;
    ptr      = NUM_REQ - 1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    pend_v    = '0;
    req_valid = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b);
    pend_v[i] = 1'b1;
    pend_a[i] = a;
    pend_b[i] = b;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_flags"}, 32'({resp_greater, resp_equal, resp_lesser, resp_error}), 32'd0);
    chk({tag, "_resp_id"}, 32'(resp_id), 32'd0);
    chk({tag, "_cmp_ops"}, 32'({cmp_a, cmp_b}), 32'd0);
    chk({tag, "_cmp_reset"}, 32'(cmp_reset), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int rbase;
    int abase;
    vecs[0] = '{0, 4'd9,  4'd3,  1'b1, 1'b0, 1'b0};
    vecs[1] = '{1, 4'd5,  4'd5,  1'b0, 1'b1, 1'b0};
    vecs[2] = '{2, 4'd2,  4'd12, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{3, 4'd15, 4'd0,  1'b1, 1'b0, 1'b0};
    vecs[4] = '{0, 4'd0,  4'd15, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{3, 4'd0,  4'd0,  1'b0, 1'b1, 1'b0};

    reset_n    = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    force_err  = 1'b0;
    rr         = 1'b0;
    pend_v     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_a[i] = '0;
      pend_b[i] = '0;
    end
    cyc = 0;
    model_reset();
    #3;
    chk_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Single-requester vectors against constant expectations.
    rr = 1'b1;
    for (int v = 0; v < 6; v++) begin
      int start;
      start = cyc;
      set_req(vecs[v].id, vecs[v].a, vecs[v].b);
      run_until(10);
      chk("vec_accept_cycle", 32'(acc_cycs[$]), 32'(start));
      chk("vec_latency", 32'(resp_cycs[$] - acc_cycs[$]), 32'd2);
      chk("vec_id", 32'(resp_ids[$]), 32'(vecs[v].id));
      chk("vec_flags", 32'({obs_gt, obs_eq, obs_lt, obs_err}),
          32'({vecs[v].gt, vecs[v].eq, vecs[v].lt, 1'b0}));
    end

    // Requesters 1 and 2 together, equal operands.
    rbase = resp_ids.size();
    abase = acc_cycs.size();
    set_req(1, 4'd5, 4'd5);
    set_req(2, 4'd5, 4'd5);
    run_until(20);
    chk("pair_count", 32'(resp_ids.size() - rbase), 32'd2);
    chk("pair_first_id", 32'(resp_ids[rbase]), 32'd1);
    chk("pair_second_id", 32'(resp_ids[rbase+1]), 32'd2);
    chk("pair_spacing", 32'(acc_cycs[abase+1] - acc_cycs[abase]), 32'd3);

    // All four continuously valid from a fresh reset: strict rotation.
    do_reset();
    rbase = resp_ids.size();
    for (int n = 0; n < 100 && resp_ids.size() < rbase + 8; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend_v[i]) set_req(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      cycle();
    end
    pend_v = '0;
    run_until(10);
    chk("rotation_count", 32'(resp_ids.size() - rbase), 32'd8);
    for (int k = 0; k < 8; k++) begin
      chk("rotation_id", 32'(resp_ids[rbase+k]), 32'(k % NUM_REQ));
    end

    // Backpressure: hold the response five cycles while requester 1 waits.
    rr = 1'b0;
    set_req(0, 4'd2, 4'd12);
    cycle();
    cycle();
    set_req(1, 4'd7, 4'd1);
    for (int k = 0; k < 5; k++) cycle();
    rr = 1'b1;
    cycle();
    cycle();
    chk("stall_lesser", 32'({obs_gt, obs_eq, obs_lt}), 32'b001);
    chk("stall_resume", 32'(acc_cycs[$] - resp_cycs[$]), 32'd1);
    chk("stall_next_id", 32'(acc_ids[$]), 32'd1);
    run_until(10);

    // Illegal comparator output is flagged and the response still completes.
    force_err = 1'b1;
    rbase = resp_ids.size();
    set_req(2, 4'd7, 4'd7);
    run_until(10);
    force_err = 1'b0;
    chk("err_done", 32'(resp_ids.size() - rbase), 32'd1);
    chk("err_flags", 32'({obs_gt, obs_eq, obs_lt, obs_err}), 32'b1101);

    // Reset during COMPARE discards the request and restores priority to 0.
    set_req(3, 4'd4, 4'd9);
    cycle();
    chk("abort_in_compare", 32'(busy), 32'd1);
    reset_n   = 1'b0;
    pend_v    = 4'b0001;
    req_valid = 4'b0001;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    pend_v = '0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rbase = resp_ids.size();
    abase = acc_ids.size();
    set_req(0, 4'd1, 4'd2);
    set_req(1, 4'd3, 4'd3);
    set_req(3, 4'd4, 4'd9);
    run_until(20);
    chk("abort_first_grant", 32'(acc_ids[abase]), 32'd0);
    chk("abort_resp_count", 32'(resp_ids.size() - rbase), 32'd3);

    // Random traffic with random backpressure and withdrawals.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend_v[i] && $urandom_range(0, 3) == 0)
          set_req(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        else if (pend_v[i] && $urandom_range(0, 15) == 0)
          pend_v[i] = 1'b0;
      end
      rr = ($urandom_range(0, 2) != 0);
      cycle();
    end
    pend_v = '0;
    rr = 1'b1;
    run_until(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
